// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one synchronous memory port among CORE_COUNT cores
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   core_enable          2 bits per core: 01 LD, 10 ST, 00/11 idle
//   core_addr            ADDR_SIZE bits per core
//   core_wr_data         REG_SIZE bits per core (ST data)
//   core_rd_data         REG_SIZE bits per core (LD data, valid with core_ready)
//   core_ready           one-cycle completion pulse per core
//   mem_addr/mem_wr_data/mem_we/mem_re   registered shared-memory request
//   mem_rd_data          memory read data, valid the cycle after mem_re
//
// Optional feature: define MEM_ARB_REGRANT_EN to let the DONE state grant the
// next waiting core directly (one access per 2 cycles instead of 3).
module mem_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int REG_SIZE   = 8,
    parameter int ADDR_SIZE  = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*CORE_COUNT-1:0]          core_enable,
    input  logic [ADDR_SIZE*CORE_COUNT-1:0]  core_addr,
    input  logic [REG_SIZE*CORE_COUNT-1:0]   core_wr_data,
    output logic [REG_SIZE*CORE_COUNT-1:0]   core_rd_data,
    output logic [CORE_COUNT-1:0]            core_ready,
    output logic [ADDR_SIZE-1:0]             mem_addr,
    output logic [REG_SIZE-1:0]              mem_wr_data,
    output logic                             mem_we,
    output logic                             mem_re,
    input  logic [REG_SIZE-1:0]              mem_rd_data
);

    localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic                   op_st_q, op_st_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [REG_SIZE-1:0]    mem_wr_data_q, mem_wr_data_d;
    logic                   mem_we_q, mem_we_d;
    logic                   mem_re_q, mem_re_d;
    logic [CORE_COUNT-1:0]  ready_q, ready_d;

    logic [1:0]             en_arr    [CORE_COUNT];
    logic [ADDR_SIZE-1:0]   addr_arr  [CORE_COUNT];
    logic [REG_SIZE-1:0]    wdata_arr [CORE_COUNT];
    logic [CORE_COUNT-1:0]  cand;
    logic                   excl_gnt;
    logic                   hi_found, any_found;
    logic [IDX_W-1:0]       hi_idx, any_idx, pick_idx, pick_nxt;
    logic                   pick_found;

    // Unpack the per-core buses, slice i belongs to core i.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            en_arr[i]    = core_enable[2*i +: 2];
            addr_arr[i]  = core_addr[ADDR_SIZE*i +: ADDR_SIZE];
            wdata_arr[i] = core_wr_data[REG_SIZE*i +: REG_SIZE];
        end
    end

    // In DONE the current grantee still holds its request; it must not be re-served.
`ifdef MEM_ARB_REGRANT_EN
    assign excl_gnt = (state_q == S_DONE);
`else
    assign excl_gnt = 1'b0;
`endif

    // Only LD/ST encodings are requests; 2'b11 is ignored entirely.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            cand[i] = (en_arr[i] == 2'b01 || en_arr[i] == 2'b10) &&
                      !(excl_gnt && gnt_q == IDX_W'(i));
        end
    end

    // Round-robin pick: lowest candidate at or above rr_ptr, else lowest overall.
    // Descending scan so the last hit is the lowest index.
    always_comb begin
        hi_found  = 1'b0;
        any_found = 1'b0;
        hi_idx    = '0;
        any_idx   = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                any_found = 1'b1;
                any_idx   = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        pick_found = any_found;
        pick_idx   = hi_found ? hi_idx : any_idx;
        pick_nxt   = (pick_idx == IDX_W'(CORE_COUNT - 1)) ? '0 : pick_idx + IDX_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        op_st_d       = op_st_q;
        mem_addr_d    = '0;
        mem_wr_data_d = '0;
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;
        ready_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    state_d       = S_ACCESS;
                    gnt_d         = pick_idx;
                    op_st_d       = (en_arr[pick_idx] == 2'b10);
                    rr_ptr_d      = pick_nxt;
                    mem_addr_d    = addr_arr[pick_idx];
                    mem_wr_data_d = wdata_arr[pick_idx];
                    mem_we_d      = (en_arr[pick_idx] == 2'b10);
                    mem_re_d      = (en_arr[pick_idx] == 2'b01);
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                for (int i = 0; i < CORE_COUNT; i++) begin
                    ready_d[i] = (gnt_q == IDX_W'(i));
                end
            end
            S_DONE: begin
`ifdef MEM_ARB_REGRANT_EN
                if (pick_found) begin
                    state_d       = S_ACCESS;
                    gnt_d         = pick_idx;
                    op_st_d       = (en_arr[pick_idx] == 2'b10);
                    rr_ptr_d      = pick_nxt;
                    mem_addr_d    = addr_arr[pick_idx];
                    mem_wr_data_d = wdata_arr[pick_idx];
                    mem_we_d      = (en_arr[pick_idx] == 2'b10);
                    mem_re_d      = (en_arr[pick_idx] == 2'b01);
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            op_st_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            ready_q       <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            op_st_q       <= op_st_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            ready_q       <= ready_d;
        end
    end

    // Load data is routed straight from memory during DONE; zero everywhere else.
    always_comb begin
        for (int i = 0; i < CORE_COUNT; i++) begin
            core_rd_data[REG_SIZE*i +: REG_SIZE] =
                (state_q == S_DONE && !op_st_q && gnt_q == IDX_W'(i)) ? mem_rd_data : '0;
        end
    end

    assign core_ready  = ready_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int N = 4;
    localparam int R = 8;
    localparam int A = 12;
`ifdef MEM_ARB_REGRANT_EN
    localparam int SP = 2;
`else
    localparam int SP = 3;
`endif

    logic             clk;
    logic             reset;
    logic [2*N-1:0]   core_enable;
    logic [A*N-1:0]   core_addr;
    logic [R*N-1:0]   core_wr_data;
    logic [R*N-1:0]   core_rd_data;
    logic [N-1:0]     core_ready;
    logic [A-1:0]     mem_addr;
    logic [R-1:0]     mem_wr_data;
    logic             mem_we;
    logic             mem_re;
    logic [R-1:0]     mem_rd_data;

    logic [R-1:0]     mem [4096];
    logic             pre_we;
    logic [A-1:0]     pre_addr;
    logic [R-1:0]     pre_data;

    int checks;
    int errors;

    mem_arbiter #(.CORE_COUNT(N), .REG_SIZE(R), .ADDR_SIZE(A)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_enable  (core_enable),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_ready   (core_ready),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rd_data  (mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wr_data;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
        if (mem_re)
            mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [A-1:0] a, input logic [R-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] en, input logic [A-1:0] a,
                           input logic [R-1:0] d);
        core_enable[2*i +: 2]  = en;
        core_addr[A*i +: A]    = a;
        core_wr_data[R*i +: R] = d;
    endtask

    task automatic clr_reqs();
        core_enable  = '0;
        core_addr    = '0;
        core_wr_data = '0;
    endtask

    int np;
    int pulse_core [5];
    int pulse_cyc  [5];
    logic [R-1:0] pulse_data [5];
    int rdy_cnt;

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        pre_we      = 1'b0;
        pre_addr    = '0;
        pre_data    = '0;
        mem_rd_data = '0;
        clr_reqs();
        set_req(1, 2'b01, 12'h123, 8'h00);

        preload(12'h123, 8'h5A);
        preload(12'h200, 8'h77);
        preload(12'h055, 8'h00);
        preload(12'h010, 8'h11);
        preload(12'h011, 8'h22);
        for (int i = 0; i < N; i++) preload(12'h300 + 12'(i), 8'hA0 + 8'(i));

        // Reset state, with a request pending that must not be granted.
        @(negedge clk);
        chk("rst_we",     mem_we, 0);
        chk("rst_re",     mem_re, 0);
        chk("rst_addr",   mem_addr, 0);
        chk("rst_wdata",  mem_wr_data, 0);
        chk("rst_ready",  core_ready, 0);
        chk("rst_rdata",  core_rd_data, 0);
        chk("rst_state",  dut.state_q, 0);
        chk("rst_rr",     dut.rr_ptr_q, 0);
        clr_reqs();
        reset = 1'b1;

        // Single LD, core 1.
        @(negedge clk);
        set_req(1, 2'b01, 12'h123, 8'h00);
        @(negedge clk);
        chk("ld_re",      mem_re, 1);
        chk("ld_we",      mem_we, 0);
        chk("ld_addr",    mem_addr, 12'h123);
        chk("ld_rdy_c1",  core_ready, 0);
        @(negedge clk);
        chk("ld_ready",   core_ready, 4'b0010);
        chk("ld_rdata",   core_rd_data, 32'h0000_5A00);
        chk("ld_re_c2",   mem_re, 0);
        clr_reqs();
        @(negedge clk);
        chk("ld_rdy_c3",  core_ready, 0);
        chk("ld_rr",      dut.rr_ptr_q, 2);

        // Single ST, core 3.
        set_req(3, 2'b10, 12'h0FF, 8'hC3);
        @(negedge clk);
        chk("st_we",      mem_we, 1);
        chk("st_re",      mem_re, 0);
        chk("st_addr",    mem_addr, 12'h0FF);
        chk("st_wdata",   mem_wr_data, 8'hC3);
        @(negedge clk);
        chk("st_ready",   core_ready, 4'b1000);
        chk("st_rdata",   core_rd_data, 0);
        chk("st_we_c2",   mem_we, 0);
        clr_reqs();
        @(negedge clk);
        chk("st_mem",     mem[12'h0FF], 8'hC3);
        chk("st_rr",      dut.rr_ptr_q, 0);

        // Illegal encoding on core 0 alongside a LD on core 2.
        set_req(0, 2'b11, 12'h055, 8'h99);
        set_req(2, 2'b01, 12'h200, 8'h00);
        @(negedge clk);
        chk("ill_re",     mem_re, 1);
        chk("ill_addr",   mem_addr, 12'h200);
        @(negedge clk);
        chk("ill_ready",  core_ready, 4'b0100);
        chk("ill_rdata",  core_rd_data, 32'h0077_0000);
        set_req(2, 2'b00, 12'h000, 8'h00);
        rdy_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (core_ready != 0 || mem_we || mem_re) rdy_cnt++;
        end
        chk("ill_ignored", rdy_cnt, 0);
        chk("ill_rr",     dut.rr_ptr_q, 3);
        chk("ill_state",  dut.state_q, 0);
        clr_reqs();

        // Reset during ACCESS of a core 1 ST.
        @(negedge clk);
        set_req(1, 2'b10, 12'h055, 8'hEE);
        @(negedge clk);
        chk("rm_we_pre",  mem_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("rm_we_now",  mem_we, 0);
        chk("rm_addr",    mem_addr, 0);
        chk("rm_ready",   core_ready, 0);
        @(negedge clk);
        chk("rm_ready2",  core_ready, 0);
        clr_reqs();
        reset = 1'b1;
        #1;
        chk("rm_state",   dut.state_q, 0);
        chk("rm_rr",      dut.rr_ptr_q, 0);
        @(negedge clk);
        chk("rm_ready3",  core_ready, 0);
        chk("rm_mem",     mem[12'h055], 8'h00);

        // Back-to-back LDs from core 2.
        set_req(2, 2'b01, 12'h010, 8'h00);
        @(negedge clk);
        chk("bb_addr1",   mem_addr, 12'h010);
        @(negedge clk);
        chk("bb_ready1",  core_ready, 4'b0100);
        chk("bb_rdata1",  core_rd_data, 32'h0011_0000);
        @(negedge clk);
        chk("bb_no_dup_r", core_ready, 0);
        chk("bb_no_dup_m", mem_re, 0);
        set_req(2, 2'b01, 12'h011, 8'h00);
        @(negedge clk);
        chk("bb_re2",     mem_re, 1);
        chk("bb_addr2",   mem_addr, 12'h011);
        @(negedge clk);
        chk("bb_ready2",  core_ready, 4'b0100);
        chk("bb_rdata2",  core_rd_data, 32'h0022_0000);
        clr_reqs();
        @(negedge clk);

        // Fairness: all four cores request LD continuously from reset.
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 12'h300 + 12'(i), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        np = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (core_ready != 0) begin
                chk("fair_onehot", $countones(core_ready), 1);
                if (np < 5) begin
                    for (int j = 0; j < N; j++)
                        if (core_ready[j]) begin
                            pulse_core[np] = j;
                            pulse_data[np] = core_rd_data[R*j +: R];
                        end
                    pulse_cyc[np] = c;
                end
                np++;
            end
        end
        chk("fair_enough", (np >= 5), 1);
        if (np >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("fair_core%0d", k), pulse_core[k], k % N);
                chk($sformatf("fair_data%0d", k), pulse_data[k], 8'hA0 + 8'(k % N));
                if (k > 0)
                    chk($sformatf("fair_gap%0d", k), pulse_cyc[k] - pulse_cyc[k-1], SP);
            end
        end
        clr_reqs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CORE_COUNT, default 4, number of core memory ports served; SHALL be 2..16.
REQ-002 Parameter REG_SIZE, default 8, data width per access.
REQ-003 Parameter ADDR_SIZE, default 12, address width; SHALL equal CORE_ID_SIZE + REG_SIZE.
REQ-004 Timing SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- core_enable  in  2*CORE_COUNT  per-core request; 2'b01 LD, 2'b10 ST, 2'b00 and 2'b11 no request.
- core_addr  in  ADDR_SIZE*CORE_COUNT  per-core address.
- core_wr_data  in  REG_SIZE*CORE_COUNT  per-core store data.
- core_rd_data  out  REG_SIZE*CORE_COUNT  per-core load data.
- core_ready  out  CORE_COUNT  per-core completion pulse.
- mem_addr  out  ADDR_SIZE  shared-memory address.
- mem_wr_data  out  REG_SIZE  shared-memory write data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- mem_rd_data  in  REG_SIZE  synchronous memory read data, valid the cycle after mem_re.
Slice i of every per-core bus SHALL belong to core i (LSB-first).

Function
REQ-006 The FSM SHALL have three states:
- IDLE: no access in flight.
- ACCESS: memory strobes driven.
- DONE: response cycle.
REQ-007 In IDLE, if any core requests, the block SHALL grant one core round-robin, latch its index, opcode, address and data, and go to ACCESS next cycle; with no request it SHALL stay in IDLE.
REQ-008 Round-robin SHALL search upward from rr_ptr modulo CORE_COUNT; after granting core g, rr_ptr SHALL become (g+1) mod CORE_COUNT.
REQ-009 mem_addr, mem_wr_data, mem_we and mem_re SHALL be registered outputs.
- During ACCESS they carry the latched request, with mem_we=1 for ST or mem_re=1 for LD.
- In every other state all four SHALL be 0.
REQ-010 ACCESS SHALL always last exactly one cycle, then go to DONE.
REQ-011 In DONE, core_ready[g] SHALL be 1 for exactly that cycle and every other core_ready bit SHALL be 0.
REQ-012 In DONE of a LD, core_rd_data slice g SHALL equal mem_rd_data combinationally; all other slices, and slice g for ST, SHALL be 0.
REQ-013 Latency SHALL be fixed: a request first seen in IDLE at cycle 0 SHALL get core_ready at cycle 2.
REQ-014 The requesting core holds its request stable until core_ready; the block SHALL sample only in IDLE (or DONE per REQ-019) and SHALL ignore request changes of non-granted cores.
REQ-015 Simultaneous requests SHALL be serviced one at a time; no core SHALL wait more than CORE_COUNT-1 grants.
REQ-016 Encoding 2'b11 SHALL never be granted and SHALL not move rr_ptr.
REQ-017 core_ready SHALL never be 1 in IDLE or ACCESS; at most one core_ready bit SHALL be 1 in any cycle.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force:
- state=IDLE, rr_ptr=0, latched grant, opcode, address and data=0;
- mem_we, mem_re, mem_addr, mem_wr_data=0;
- core_ready=0, core_rd_data=0.
A request in flight when reset asserts SHALL be dropped without a ready pulse. The first grant SHALL occur no earlier than the first rising edge after reset deasserts.

Configuration
REQ-019 Macro MEM_ARB_REGRANT_EN SHALL select the DONE exit:
- Defined: in DONE, if any core other than g requests, the block SHALL grant it (round-robin, excluding g) and go directly to ACCESS, giving one access per 2 cycles; otherwise go to IDLE.
- Undefined: DONE SHALL always go to IDLE, giving one access per 3 cycles.
The granted core's still-asserted request SHALL never be re-granted in DONE.

Verification
REQ-020 Single LD: core 1 issues LD addr 0x123 with memory [0x123]=0x5A. Expect mem_re=1 and mem_addr=0x123 at cycle 1, core_ready=4'b0010 and core_rd_data slice 1=0x5A at cycle 2.
REQ-021 Single ST: core 3 issues ST addr 0x0FF data 0xC3. Expect mem_we=1, mem_addr=0x0FF and mem_wr_data=0xC3 at cycle 1, core_ready=4'b1000 at cycle 2, and memory [0x0FF]=0xC3 afterwards.
REQ-022 Fairness: all four cores request LD continuously from reset.
- Grant order SHALL be 0,1,2,3,0.
- Ready pulses SHALL be 3 cycles apart without MEM_ARB_REGRANT_EN and 2 cycles apart with it.
REQ-023 Illegal encoding: core 0 drives 2'b11 and core 2 drives LD. Core 2 SHALL be served, core 0 SHALL never get core_ready, and rr_ptr SHALL become 3.
REQ-024 Reset mid-operation: reset=0 during ACCESS of a core 1 ST. Expect mem_we=0 immediately, no core_ready pulse, and state IDLE with rr_ptr=0 after release.
REQ-025 Back-to-back same core: core 2 issues LD 0x010 and then LD 0x011 in the cycle after its ready. Expect two distinct accesses with correct data each, and the first request never serviced twice.
